score_keeper: RTL and testbench
===============================

# score_keeper

Match-level scorer placed directly downstream of `playfield`. Consumes its `winner` code, tallies round wins per player, and shows both tallies on two seven-segment digits. After each round it issues a one-cycle `round_reset` pulse back to `playfield`, so play resumes without the user pressing reset. The match ends when either player reaches `MAX_SCORE`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles the winning LED pattern is held before `round_reset`. Must be ≥1. Board builds override this to a large value.
- `MAX_SCORE`, default 7: wins needed to end the match. Range 1–7.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high; clears the whole match.
- `winner`  in  2  from `playfield`: 2'b00 = none, 2'b10 = left wins, 2'b01 = right wins, 2'b11 = illegal (treated as 2'b00).
- `round_reset`  out  1  one-cycle pulse, ORed with `reset` into `playfield` by the top level.
- `left_score`  out  3  left player's win count.
- `right_score`  out  3  right player's win count.
- `game_over`  out  1  high once either score equals `MAX_SCORE`.
- `HEX_L`  out  7  active-low segments {g..a} for `left_score`.
- `HEX_R`  out  7  active-low segments {g..a} for `right_score`.

## Operation
FSM states: PLAY, HOLD, RESTART, WAIT_CLEAR, GAME_OVER.
- PLAY: if `winner` is 2'b10, increment `left_score`; if 2'b01, increment `right_score`. Next state:
  - GAME_OVER if the new score equals `MAX_SCORE`.
  - Otherwise HOLD, with `hold_cnt` loaded to `HOLD_CYCLES-1`.
- PLAY with 2'b00 or 2'b11: no change.
- HOLD: decrement `hold_cnt`. Go to RESTART when `hold_cnt`==0 at the clock edge.
- RESTART: `round_reset`=1 for exactly this state, one cycle. Then WAIT_CLEAR.
- WAIT_CLEAR: stay until `winner`==2'b00 is sampled, then PLAY. This prevents a stale `winner` being counted twice.
- GAME_OVER: `game_over`=1 and `round_reset`=0. Scores are frozen and `winner` is ignored. Only `reset` exits this state.
- Scores never exceed `MAX_SCORE`. No wrap-around.
- `winner` is ignored in every state except PLAY.
- `reset` in any state, including mid-HOLD or during RESTART, wins over everything:
  - next state PLAY;
  - scores 0, `hold_cnt` 0, `round_reset` 0, `game_over` 0.
- Hex decode is combinational from the registered scores. The digits are 0–7 only: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000.

## Timing
- Reset values: `left_score`=0, `right_score`=0, `round_reset`=0, `game_over`=0, `HEX_L`=`HEX_R`=7'b1000000, state PLAY.
- Let t0 be the edge at which a valid `winner` is sampled in PLAY:
  - the score is updated after t0 (one-cycle latency);
  - `round_reset` is high during the cycle following edge t0+`HOLD_CYCLES`, i.e. `HOLD_CYCLES` full cycles after the score update.
- `game_over` rises in the same cycle as the final score update. No `round_reset` is issued for the final round.
- `round_reset` is registered, so the output is glitch-free.
- `playfield` clears `winner` on the edge after the pulse. WAIT_CLEAR therefore normally lasts one cycle.

## Structure
- Shared package `tug_pkg`:
  - `winner_t` enum (`WIN_NONE`, `WIN_RIGHT`=2'b01, `WIN_LEFT`=2'b10);
  - `score_state_t` enum for the five states;
  - the `SEG_BLANK` and digit-pattern constants.
- One sub-module, `seg7_digit`: 3-bit value in, 7-bit active-low segments out. It is instantiated twice.
- `hold_cnt` width is `$clog2(HOLD_CYCLES+1)`.

## Test plan
All cases use `HOLD_CYCLES`=4 and `MAX_SCORE`=3.
- Reset, with `winner`=00 for 5 cycles -> scores 0/0, `HEX_L`=`HEX_R`=7'b1000000, `round_reset` never high.
- `winner`=10 held until after `round_reset`, then 00 -> `left_score`=1 one cycle after sampling, `HEX_L`=7'b1111001, `round_reset` high exactly 1 cycle, 4 cycles after the score update, and no second increment.
- Three right wins separated by clears -> `right_score`=3, `game_over`=1 on the third update, no third `round_reset`, and further `winner`=01/10 leave the scores at 0/3.
- `winner`=11 in PLAY, and `winner`=01 pulsed during HOLD and WAIT_CLEAR -> no score change beyond the original win.
- `reset` asserted during the 2nd HOLD cycle after a left win -> next cycle scores 0/0, state PLAY, no `round_reset` pulse.
- `reset` in GAME_OVER, then `winner`=10 -> `game_over`=0, `left_score`=1 and counting resumes normally.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war match logic.
// Winner codes, scorer states and seven-segment patterns.
package tug_pkg;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_RIGHT = 2'b01,
    WIN_LEFT  = 2'b10
  } winner_t;

  typedef enum logic [2:0] {
    PLAY,
    HOLD,
    RESTART,
    WAIT_CLEAR,
    GAME_OVER
  } score_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;

endpackage

// File: rtl/seg7_digit.sv
// Seven-segment decoder for a single 0-7 digit.
// Active-low segments ordered {g..a}.
module seg7_digit
  import tug_pkg::*;
(
  input  logic [2:0] value,
  output logic [6:0] seg
);

  // Map the digit value to its segment pattern.
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      3'd0: seg = SEG_0;
      3'd1: seg = SEG_1;
      3'd2: seg = SEG_2;
      3'd3: seg = SEG_3;
      3'd4: seg = SEG_4;
      3'd5: seg = SEG_5;
      3'd6: seg = SEG_6;
      3'd7: seg = SEG_7;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Match scorer: tallies round wins, pulses round_reset
// after a hold period and stops at MAX_SCORE.
module score_keeper
  import tug_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_SCORE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] winner,
  output logic       round_reset,
  output logic [2:0] left_score,
  output logic [2:0] right_score,
  output logic       game_over,
  output logic [6:0] HEX_L,
  output logic [6:0] HEX_R
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0] MAX_S = 3'(MAX_SCORE);

  score_state_t  state, state_n;
  logic [2:0]    left_n, right_n;
  logic [CW-1:0] hold_cnt, hold_n;

  // Next-state, score and hold-counter logic.
  always_comb begin
    state_n = state;
    left_n  = left_score;
    right_n = right_score;
    hold_n  = hold_cnt;
    unique case (state)
      PLAY: begin
        if (winner == WIN_LEFT) begin
          left_n  = left_score + 3'd1;
          hold_n  = HOLD_LOAD;
          state_n = (left_n == MAX_S) ? GAME_OVER : HOLD;
        end else if (winner == WIN_RIGHT) begin
          right_n = right_score + 3'd1;
          hold_n  = HOLD_LOAD;
          state_n = (right_n == MAX_S) ? GAME_OVER : HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_n = RESTART;
        else hold_n = hold_cnt - 1'b1;
      end
      RESTART: state_n = WAIT_CLEAR;
      WAIT_CLEAR: begin
        if (winner == WIN_NONE) state_n = PLAY;
      end
      GAME_OVER: state_n = GAME_OVER;
      default: state_n = PLAY;
    endcase
  end

  // State, scores and registered round_reset / game_over.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLAY;
      left_score  <= '0;
      right_score <= '0;
      hold_cnt    <= '0;
      round_reset <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      left_score  <= left_n;
      right_score <= right_n;
      hold_cnt    <= hold_n;
      round_reset <= (state_n == RESTART);
      game_over   <= (state_n == GAME_OVER);
    end
  end

  seg7_digit u_hex_l (
    .value (left_score),
    .seg   (HEX_L)
  );

  seg7_digit u_hex_r (
    .value (right_score),
    .seg   (HEX_R)
  );

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with HOLD_CYCLES=4,
// MAX_SCORE=3.
module tb_score_keeper;

  logic       clk;
  logic       reset;
  logic [1:0] winner;
  logic       round_reset;
  logic [2:0] left_score;
  logic [2:0] right_score;
  logic       game_over;
  logic [6:0] HEX_L;
  logic [6:0] HEX_R;

  int compared   = 0;
  int mismatched = 0;
  int rr_cnt     = 0;

  score_keeper #(
    .HOLD_CYCLES (4),
    .MAX_SCORE   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .winner      (winner),
    .round_reset (round_reset),
    .left_score  (left_score),
    .right_score (right_score),
    .game_over   (game_over),
    .HEX_L       (HEX_L),
    .HEX_R       (HEX_R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with round_reset high.
  always @(posedge clk) if (round_reset) rr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    winner = 2'b00;
    tick();
    reset = 1'b0;
    rr_cnt = 0;
  endtask

  // Tick until round_reset is seen, bounded; returns cycles.
  task automatic wait_rr(output int n);
    n = 0;
    while (!round_reset && n < 20) begin
      tick();
      n++;
    end
  endtask

  // One full non-final round: win, clear, pulse, back to PLAY.
  task automatic win_round(input logic [1:0] w, output int n);
    winner = w;
    tick();
    winner = 2'b00;
    wait_rr(n);
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    winner = 2'b00;
    tick();
    tick();
    compared++;
    if (left_score !== 3'd0 || right_score !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_hold_scores: got %0d/%0d want 0/0",
               left_score, right_score);
    end
    reset  = 1'b0;
    rr_cnt = 0;
    repeat (5) tick();
    compared++;
    if (left_score !== 3'd0 || right_score !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_scores: got %0d/%0d want 0/0",
               left_score, right_score);
    end
    compared++;
    if (HEX_L !== 7'b1000000 || HEX_R !== 7'b1000000) begin
      mismatched++;
      $display("FAIL reset_hex: got %b/%b want 1000000/1000000",
               HEX_L, HEX_R);
    end
    compared++;
    if (game_over !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_game_over: got %b want 0", game_over);
    end
    compared++;
    if (rr_cnt !== 0) begin
      mismatched++;
      $display("FAIL reset_no_rr: got %0d pulses want 0", rr_cnt);
    end
  endtask

  task automatic test_left_win();
    int n;
    do_reset();
    winner = 2'b10;
    tick();
    compared++;
    if (left_score !== 3'd1 || right_score !== 3'd0) begin
      mismatched++;
      $display("FAIL left_win_score: got %0d/%0d want 1/0",
               left_score, right_score);
    end
    compared++;
    if (HEX_L !== 7'b1111001) begin
      mismatched++;
      $display("FAIL left_win_hex: got %b want 1111001", HEX_L);
    end
    compared++;
    if (round_reset !== 1'b0) begin
      mismatched++;
      $display("FAIL left_win_rr_early: got %b want 0", round_reset);
    end
    wait_rr(n);
    compared++;
    if (n !== 4) begin
      mismatched++;
      $display("FAIL left_win_rr_delay: got %0d want 4", n);
    end
    tick();
    compared++;
    if (round_reset !== 1'b0) begin
      mismatched++;
      $display("FAIL left_win_rr_width: got %b want 0", round_reset);
    end
    winner = 2'b00;
    repeat (4) tick();
    compared++;
    if (left_score !== 3'd1 || rr_cnt !== 1) begin
      mismatched++;
      $display("FAIL left_win_once: got left=%0d rr=%0d want 1/1",
               left_score, rr_cnt);
    end
  endtask

  task automatic test_right_game_over();
    int n;
    do_reset();
    win_round(2'b01, n);
    compared++;
    if (right_score !== 3'd1 || n !== 4) begin
      mismatched++;
      $display("FAIL right_r1: got %0d delay %0d want 1 delay 4",
               right_score, n);
    end
    win_round(2'b01, n);
    compared++;
    if (right_score !== 3'd2 || game_over !== 1'b0) begin
      mismatched++;
      $display("FAIL right_r2: got %0d go=%b want 2 go=0",
               right_score, game_over);
    end
    winner = 2'b01;
    tick();
    compared++;
    if (right_score !== 3'd3 || game_over !== 1'b1) begin
      mismatched++;
      $display("FAIL right_final: got %0d go=%b want 3 go=1",
               right_score, game_over);
    end
    compared++;
    if (HEX_R !== 7'b0110000) begin
      mismatched++;
      $display("FAIL right_hex3: got %b want 0110000", HEX_R);
    end
    repeat (8) tick();
    winner = 2'b10;
    repeat (8) tick();
    winner = 2'b00;
    tick();
    compared++;
    if (rr_cnt !== 2) begin
      mismatched++;
      $display("FAIL right_no_third_rr: got %0d want 2", rr_cnt);
    end
    compared++;
    if (left_score !== 3'd0 || right_score !== 3'd3 ||
        game_over !== 1'b1) begin
      mismatched++;
      $display("FAIL right_frozen: got %0d/%0d go=%b want 0/3 go=1",
               left_score, right_score, game_over);
    end
  endtask

  task automatic test_ignored_winner();
    int n;
    do_reset();
    winner = 2'b11;
    repeat (3) tick();
    compared++;
    if (left_score !== 3'd0 || right_score !== 3'd0) begin
      mismatched++;
      $display("FAIL illegal_code: got %0d/%0d want 0/0",
               left_score, right_score);
    end
    winner = 2'b10;
    tick();
    winner = 2'b01;
    tick();
    tick();
    wait_rr(n);
    tick();
    tick();
    tick();
    winner = 2'b00;
    tick();
    tick();
    compared++;
    if (left_score !== 3'd1 || right_score !== 3'd0) begin
      mismatched++;
      $display("FAIL ignored_hold_wait: got %0d/%0d want 1/0",
               left_score, right_score);
    end
    compared++;
    if (rr_cnt !== 1) begin
      mismatched++;
      $display("FAIL ignored_rr_count: got %0d want 1", rr_cnt);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    winner = 2'b10;
    tick();
    winner = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    compared++;
    if (left_score !== 3'd0 || right_score !== 3'd0 ||
        round_reset !== 1'b0 || game_over !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_hold_reset: got %0d/%0d rr=%b go=%b want 0/0 0 0",
               left_score, right_score, round_reset, game_over);
    end
    reset = 1'b0;
    repeat (8) tick();
    compared++;
    if (rr_cnt !== 0) begin
      mismatched++;
      $display("FAIL mid_hold_no_rr: got %0d want 0", rr_cnt);
    end
    winner = 2'b01;
    tick();
    winner = 2'b00;
    compared++;
    if (right_score !== 3'd1 || left_score !== 3'd0) begin
      mismatched++;
      $display("FAIL mid_hold_play: got %0d/%0d want 0/1",
               left_score, right_score);
    end
  endtask

  task automatic test_reset_game_over();
    int n;
    do_reset();
    win_round(2'b10, n);
    win_round(2'b10, n);
    winner = 2'b10;
    tick();
    winner = 2'b00;
    compared++;
    if (left_score !== 3'd3 || game_over !== 1'b1) begin
      mismatched++;
      $display("FAIL go_reach: got %0d go=%b want 3 go=1",
               left_score, game_over);
    end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (game_over !== 1'b0 || left_score !== 3'd0) begin
      mismatched++;
      $display("FAIL go_reset: got %0d go=%b want 0 go=0",
               left_score, game_over);
    end
    winner = 2'b10;
    tick();
    compared++;
    if (left_score !== 3'd1 || game_over !== 1'b0 ||
        HEX_L !== 7'b1111001) begin
      mismatched++;
      $display("FAIL go_resume: got %0d go=%b hex=%b want 1 0 1111001",
               left_score, game_over, HEX_L);
    end
    wait_rr(n);
    compared++;
    if (n !== 4) begin
      mismatched++;
      $display("FAIL go_resume_rr: got %0d want 4", n);
    end
    winner = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    winner = 2'b00;
    test_reset();
    test_left_win();
    test_right_game_over();
    test_ignored_winner();
    test_reset_mid_hold();
    test_reset_game_over();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
